// File: rtl/alu_multicycle.sv
// alu_multicycle: parametrised EX-stage ALU with a valid/ready handshake.
// Single-cycle ops complete on the accept edge; MULTU/DIVU iterate one
// radix-2 step per cycle in BUSY and report through the same result registers.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_SRA   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOR   = 4'd9;
    localparam logic [3:0] OP_LEU   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    // Iteration state: opnd is the multiplicand (MULTU) or divisor (DIVU);
    // {acc_hi, acc_lo} is the product/partial-remainder:quotient register.
    logic [SHW:0]       cnt;
    logic               is_div;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               accept;
    logic               start_iter;
    logic [WIDTH:0]     alu_out;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    // Single-cycle operations; returns {ovf, result}.
    function automatic logic [WIDTH:0] alu_op(input logic [3:0]       op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [WIDTH-1:0]        r;
        logic                    v;
        logic [SHW-1:0]          sh;
        xs = x;
        ys = y;
        sh = y[SHW-1:0];
        r  = '0;
        v  = 1'b0;
        case (op)
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_ADD: begin
                r = x + y;
                v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                r = x - y;
                v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            OP_XOR: r = x ^ y;
            OP_LEU: r[0] = (x <= y);
            OP_SLL: r = x << sh;
            OP_SRL: r = x >> sh;
            OP_SRA: r = xs >>> sh;
            OP_SLT: r[0] = (xs < ys);
            OP_NOR: r = ~(x | y);
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    assign accept     = in_valid & in_ready;
    assign start_iter = (ctr == OP_MULTU) || (ctr == OP_DIVU);
    assign alu_out    = alu_op(ctr, a, b);
    assign out_valid  = (state == DONE);

    // One radix-2 step: shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = start_iter ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt == 1) state_n = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) state_n = start_iter ? BUSY : DONE;
                    else          state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand latch, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            is_div    <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            if (start_iter) begin
                is_div <= (ctr == OP_DIVU);
                opnd   <= (ctr == OP_DIVU) ? b : a;
                acc_lo <= (ctr == OP_DIVU) ? a : b;
                acc_hi <= '0;
                cnt    <= (SHW+1)'(WIDTH);
            end else begin
                result    <= alu_out[WIDTH-1:0];
                result_hi <= '0;
                ovf       <= alu_out[WIDTH];
                zero      <= (alu_out[WIDTH-1:0] == '0);
            end
        end else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == 1) begin
                result    <= step_lo;
                result_hi <= step_hi;
                ovf       <= 1'b0;
                zero      <= (step_lo == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle: table-driven vectors through a scoreboard,
// plus hand sequences for iteration latency, backpressure and mid-op reset.
module tb_alu_multicycle;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        ovf;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        o;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctr       (ctr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a result is consumed at each edge where out_valid & out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got res=%h hi=%h, expected nothing", result, result_hi);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (result !== e.res || result_hi !== e.hi || zero !== e.z || ovf !== e.o) begin
                    errors++;
                    $display("FAIL result: got res=%h hi=%h z=%b o=%b, expected res=%h hi=%h z=%b o=%b",
                             result, result_hi, zero, ovf, e.res, e.hi, e.z, e.o);
                end
            end
        end
    end

    // Present one op; returns just after the accept edge with in_valid dropped.
    task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input exp_t e);
        int n;
        in_valid = 1'b1;
        ctr      = op;
        a        = x;
        b        = y;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
                in_valid = 1'b0;
                return;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
    endtask

    vec_t vecs[20];
    int   nv;

    initial begin
        int   busy;
        logic stable;
        logic rdy_low;

        nv = 0;
        vecs[nv++] = '{4'd0,  32'h0000_00F0, 32'h0000_0F0F, '{32'h0000_0000, 32'h0, 1'b1, 1'b0}};
        vecs[nv++] = '{4'd1,  32'h0000_00F0, 32'h0000_0F0F, '{32'h0000_0FFF, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd2,  32'h0000_00F0, 32'h0000_0F0F, '{32'h0000_0FFF, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd6,  32'h0000_00F0, 32'h0000_0F0F, '{32'hFFFF_F1E1, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd8,  32'h0000_00F0, 32'h0000_0F0F, '{32'h0000_0FFF, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd10, 32'h0000_00F0, 32'h0000_0F0F, '{32'h0000_0001, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 32'h0, 1'b0, 1'b1}};
        vecs[nv++] = '{4'd5,  32'h8000_0010, 32'h0000_0004, '{32'hF800_0001, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0001, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 32'h0, 1'b1, 1'b0}};
        vecs[nv++] = '{4'd9,  32'h0000_0000, 32'h0000_0000, '{32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd3,  32'h0000_0001, 32'h0000_003F, '{32'h8000_0000, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd4,  32'h8000_0000, 32'h0000_001F, '{32'h0000_0001, 32'h0, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd6,  32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1}};
        vecs[nv++] = '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h0, 1'b1, 1'b0}};
        vecs[nv++] = '{4'd15, 32'h1234_5678, 32'h9ABC_DEF0, '{32'h0000_0000, 32'h0, 1'b1, 1'b0}};
        vecs[nv++] = '{4'd13, 32'd100,       32'd7,         '{32'd14,        32'd2, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd13, 32'd5,         32'd0,         '{32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0}};
        vecs[nv++] = '{4'd13, 32'hFFFF_FFFF, 32'd10,        '{32'h1999_9999, 32'd5, 1'b0, 1'b0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctr       = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 ||
            result_hi !== 32'h0 || zero !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b ir=%b res=%h hi=%h z=%b o=%b, expected 0 1 0 0 0 0",
                     out_valid, in_ready, result, result_hi, zero, ovf);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < nv; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
        drain();

        // MULTU latency: in_ready low for 32 cycles, then the result.
        @(posedge clk);
        #1;
        send(4'd12, 32'hFFFF_FFFF, 32'd2, '{32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0});
        busy    = 0;
        rdy_low = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid || busy > 40) break;
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            busy++;
        end
        checks++;
        if (busy != 32 || !rdy_low) begin
            errors++;
            $display("FAIL multu_latency: busy=%0d in_ready_low=%b, expected 32 1", busy, rdy_low);
        end
        drain();

        // Backpressure: hold a result for 5 cycles, then accept back-to-back.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'd2, 32'd10, 32'd20, '{32'd30, 32'h0, 1'b0, 1'b0});
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd30 || result_hi !== 32'h0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL backpressure_hold: ov=%b ir=%b res=%h, expected 1 0 0000001e",
                     out_valid, in_ready, result);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd2, 32'd3, 32'd4, '{32'd7, 32'h0, 1'b0, 1'b0});
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd7) begin
            errors++;
            $display("FAIL no_bubble: ov=%b res=%h, expected 1 00000007", out_valid, result);
        end
        drain();

        // Reset in the middle of a MULTU discards it.
        @(posedge clk);
        #1;
        send(4'd12, 32'h0000_1234, 32'h0000_5678, '{32'h0, 32'h0, 1'b0, 1'b0});
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 ||
            result_hi !== 32'h0 || zero !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: ov=%b ir=%b res=%h hi=%h z=%b o=%b, expected 0 1 0 0 0 0",
                     out_valid, in_ready, result, result_hi, zero, ovf);
        end
        @(posedge clk);
        #1;
        send(4'd2, 32'd1, 32'd1, '{32'd2, 32'h0, 1'b0, 1'b0});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
